decoder_hold: RTL and testbench

- Sequential binary-to-one-hot decoder; the decode-side partner of the 8-to-3 encoder.
- Accepts a 3-bit code on a valid/ready handshake.
- Drives the matching one-hot 8-bit word for a fixed, parameterised number of cycles, then releases it.
- Keeps a saturating count of accepted codes. It feeds one-hot select lines, such as LED or stage enables, that must stay stable for a defined dwell time.

---
 rtl/decoder_hold.sv | 79 +++++++
 tb/tb_decoder_hold.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_hold.sv
// rtl/decoder_hold.sv - sequential binary-to-one-hot decoder with fixed dwell time
module decoder_hold #(
    parameter int IN_W        = 3,
    parameter int HOLD_CYCLES = 100,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_code,
    output logic [2**IN_W-1:0]   out_onehot,
    output logic                 out_valid,
    output logic                 busy,
    output logic [CNT_W-1:0]     decode_cnt
);
    localparam int OUT_W  = 2**IN_W;
    localparam int HOLD_W = 16;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state, state_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic [OUT_W-1:0]    onehot_n;
    logic                valid_n;
    logic                busy_n;
    logic [CNT_W-1:0]    cnt_n;
    logic                accept;

    // Ready depends on registered state only, so the final hold cycle can take a new code.
    assign in_ready = (state == IDLE) || (state == HOLD && hold_cnt == '0);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        onehot_n   = out_onehot;
        valid_n    = out_valid;
        busy_n     = busy;
        cnt_n      = decode_cnt;
        if (accept) begin
            state_n    = HOLD;
            hold_cnt_n = HOLD_W'(HOLD_CYCLES - 1);
            onehot_n   = OUT_W'(1) << in_code;
            valid_n    = 1'b1;
            busy_n     = 1'b1;
            if (decode_cnt != '1) begin
                cnt_n = decode_cnt + CNT_W'(1);
            end
        end else if (state == HOLD) begin
            if (hold_cnt != '0) begin
                hold_cnt_n = hold_cnt - HOLD_W'(1);
            end else begin
                state_n  = IDLE;
                onehot_n = '0;
                valid_n  = 1'b0;
                busy_n   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            out_onehot <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            decode_cnt <= '0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_cnt_n;
            out_onehot <= onehot_n;
            out_valid  <= valid_n;
            busy       <= busy_n;
            decode_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_decoder_hold.sv
// tb/tb_decoder_hold.sv - scoreboard bench for decoder_hold across three parameter sets
module tb_decoder_hold;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        valid [3];
    logic [2:0]  code  [3];
    logic        ready [3];
    logic [7:0]  onehot[3];
    logic        ovalid[3];
    logic        busy_s[3];
    logic [15:0] cnt   [3];
    logic [2:0]  cnt_c;
    assign cnt[2] = {13'b0, cnt_c};

    decoder_hold #(.IN_W(3), .HOLD_CYCLES(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(valid[0]), .in_ready(ready[0]), .in_code(code[0]),
        .out_onehot(onehot[0]), .out_valid(ovalid[0]), .busy(busy_s[0]), .decode_cnt(cnt[0]));
    decoder_hold #(.IN_W(3), .HOLD_CYCLES(100), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(valid[1]), .in_ready(ready[1]), .in_code(code[1]),
        .out_onehot(onehot[1]), .out_valid(ovalid[1]), .busy(busy_s[1]), .decode_cnt(cnt[1]));
    decoder_hold #(.IN_W(3), .HOLD_CYCLES(1), .CNT_W(3)) dut_c (
        .clk(clk), .rst(rst), .in_valid(valid[2]), .in_ready(ready[2]), .in_code(code[2]),
        .out_onehot(onehot[2]), .out_valid(ovalid[2]), .busy(busy_s[2]), .decode_cnt(cnt_c));

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic        mon_en = 1'b0;
    logic [23:0] exp_q [3][$];
    int          hold_of[3] = '{4, 100, 1};
    int          max_of [3] = '{65535, 65535, 7};
    int          mcnt   [3] = '{0, 0, 0};
    int          acc_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Each accepted code owes the monitor HOLD_CYCLES words carrying the post-accept count.
    task automatic acc(input int k, input logic [2:0] c);
        int n = 0;
        valid[k] = 1'b1;
        code[k]  = c;
        while (!ready[k] && n < 300) begin
            step();
            n++;
        end
        if (!ready[k]) begin
            chk("accept_timeout", 32'(ready[k]), 32'd1);
        end else begin
            if (mcnt[k] < max_of[k]) mcnt[k]++;
            for (int i = 0; i < hold_of[k]; i++)
                exp_q[k].push_back({mcnt[k][15:0], 8'b1 << c});
        end
        step();
        acc_cyc = cyc;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy_s[k] && n < 300) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy_s[k]), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (ovalid[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        chk("unexpected_word", {24'd0, onehot[k]}, 32'd0);
                    end else begin
                        logic [23:0] e;
                        e = exp_q[k].pop_front();
                        chk("onehot", {24'd0, onehot[k]}, {24'd0, e[7:0]});
                        chk("decode_cnt", {16'd0, cnt[k]}, {16'd0, e[23:8]});
                    end
                end else begin
                    chk("idle_zero", {23'd0, ovalid[k], onehot[k]}, 32'd0);
                end
            end
        end
    end

    initial begin
        int prev;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0;
            code[k]  = 3'd0;
        end
        // 1: reset then idle
        #2;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_onehot", {24'd0, onehot[0]}, 32'd0);
        chk("rst_valid", 32'(ovalid[0]), 32'd0);
        chk("rst_busy", 32'(busy_s[0]), 32'd0);
        chk("rst_ready", 32'(ready[0]), 32'd1);
        chk("rst_cnt", {16'd0, cnt[0]}, 32'd0);
        mon_en = 1'b1;

        // 2: single decode of code 5
        acc(0, 3'd5);
        valid[0] = 1'b0;
        chk("t2_busy", 32'(busy_s[0]), 32'd1);
        wait_idle(0);
        chk("t2_ready", 32'(ready[0]), 32'd1);
        chk("t2_cnt", {16'd0, cnt[0]}, 32'd1);
        chk("t2_q_empty", exp_q[0].size(), 32'd0);

        // 3: sweep 0..7 back-to-back, one accept every 4 cycles
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            acc(0, 3'(i));
            if (i > 0) chk("t3_gap", 32'(acc_cyc - prev), 32'd4);
            prev = acc_cyc;
        end
        valid[0] = 1'b0;
        wait_idle(0);
        chk("t3_cnt", {16'd0, cnt[0]}, 32'd9);
        chk("t3_q_empty", exp_q[0].size(), 32'd0);

        // 4: code changes during hold are ignored
        acc(0, 3'd2);
        code[0] = 3'd7;
        for (int i = 0; i < 3; i++) begin
            chk("t4_ready_low", 32'(ready[0]), 32'd0);
            chk("t4_hold_word", {24'd0, onehot[0]}, 32'h04);
            step();
        end
        valid[0] = 1'b0;
        wait_idle(0);
        chk("t4_q_empty", exp_q[0].size(), 32'd0);

        // 5: reset aborts a long hold at hold cycle 10
        acc(1, 3'd6);
        valid[1] = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q[k].delete();
            mcnt[k] = 0;
        end
        chk("t5_onehot", {24'd0, onehot[1]}, 32'd0);
        chk("t5_valid", 32'(ovalid[1]), 32'd0);
        chk("t5_busy", 32'(busy_s[1]), 32'd0);
        chk("t5_cnt", {16'd0, cnt[1]}, 32'd0);
        acc(1, 3'd1);
        valid[1] = 1'b0;
        chk("t5_after", {24'd0, onehot[1]}, 32'h02);
        wait_idle(1);
        chk("t5_q_empty", exp_q[1].size(), 32'd0);

        // 6: count saturates at 7 with one word per cycle
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            acc(2, 3'(i % 8));
            if (i > 0) chk("t6_gap", 32'(acc_cyc - prev), 32'd1);
            prev = acc_cyc;
        end
        valid[2] = 1'b0;
        wait_idle(2);
        chk("t6_cnt_sat", {16'd0, cnt[2]}, 32'd7);
        step();
        step();
        for (int k = 0; k < 3; k++) chk("final_q_empty", exp_q[k].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
